reg_bank_sched: RTL
===================

// Module: reg_bank_sched
// PURPOSE
//  Two-requester scheduler for the 8x16 general-purpose register bank (single write
//  port inId/ldR/rIn, single read port outId/rOut). Shares the bank between the stack
//  unit (port 0) and the ALU writeback/operand path (port 1) with round-robin
//  arbitration, plus an optional lock for atomic read-modify-write.
//  Drives the bank control pins; every bank-facing output is registered.
// PARAMETERS
//  DW        16  data width; equals the bank register width
//  AW        3   register index width (8 registers)
//  LOCK_MAX  15  max cycles a lock may be held (used only with RB_LOCK_TIMEOUT_EN)
// PORTS
//  clk        in   1   system clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  req0/req1  in   1   access request; held high until the matching gnt pulse
//  we0/we1    in   1   1 = write wdataN to addrN, 0 = read addrN
//  addr0/1    in   AW  register index
//  wdata0/1   in   DW  write data
//  lock0/1    in   1   keep ownership after grant (atomic RMW sequence)
//  gnt0/gnt1  out  1   one-cycle pulse: request accepted this cycle
//  rvalid0/1  out  1   one-cycle pulse: rdata holds this port's read result
//  rdata      out  DW  read result, shared by both ports
//  lock_err   out  1   sticky; a lock was force-released (RB_LOCK_TIMEOUT_EN only)
//  rb_inId    out  AW  bank write index
//  rb_ldR     out  1   bank load strobe
//  rb_rIn     out  DW  bank write data
//  rb_outId   out  AW  bank read index
//  rb_rOut    in   DW  bank read data, combinational from rb_outId
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; priority pointer=0; lock counter=0.
//  FSM states:
//   IDLE  - arbitrate. Single request wins. Both requesting: port = pointer.
//           Winner gets gnt. Pointer <= ~winner.
//           Winner lock=1 -> OWN_<winner>, else stay IDLE.
//   OWN0/OWN1 - only the owner may be granted; the other port waits.
//           Owner lock=0 sampled -> IDLE. That cycle arbitrates normally.
//           The owner's final request in that cycle may still be granted.
//  Grant cycle T: gntN=1 in cycle T, combinational from sampled req and state.
//  Max one grant per cycle. Requester may drop req after seeing gnt.
//  Write granted at T:
//   - rb_inId/rb_rIn/rb_ldR=1 registered, visible in T+1 only.
//   - rb_ldR is a one-cycle pulse, never two consecutive cycles for the same grant.
//  Read granted at T:
//   - rb_outId registered in T+1.
//   - rdata <= rb_rOut at end of T+1; rvalidN=1 in T+2. Latency 2 cycles.
//   - rb_outId holds its last value when idle.
//  Read-after-write: a read granted in T+1 to the index written at T returns new data.
//   The bank updates on the T+1 ldR and the read samples at end of T+2.
//  Back-to-back grants allowed every cycle; reads and writes may overlap in the pipeline.
//  Req with gnt withheld: inputs must stay stable. Changing them is undefined.
//  Reset mid-operation:
//   - pending rvalid and rb_ldR are cancelled; no bank write occurs after reset.
//   - locks are cleared.
//  Same-port repeated requests while not owner: fairness by pointer only.
//   No starvation: the loser wins the next contested cycle.
// CONFIGURATION
//  RB_LOCK_TIMEOUT_EN defined:
//   - 4-bit counter increments each cycle in OWN0/OWN1.
//   - Counter reaching LOCK_MAX -> FSM forced to IDLE, lock_err set (sticky until reset).
//   - Owner lock is ignored until that port's lock input is observed low.
//  Not defined: no counter; lock held indefinitely; lock_err tied 0.
// TESTING
//  1 reset; req0 we0=1 addr0=3 wdata0=16'hBEEF -> gnt0 @T; T+1: rb_ldR=1, rb_inId=3, rb_rIn=BEEF
//  2 then req1 we1=0 addr1=3 -> gnt1 @T'; rb_outId=3 @T'+1; rvalid1=1, rdata=BEEF @T'+2
//  3 req0,req1 both high 4 cycles, no lock -> grants alternate 0,1,0,1 from reset pointer
//  4 lock0=1: read r5, then write r5; req1 high throughout
//    -> gnt1 withheld until cycle after lock0 falls; then gnt1
//  5 write r2=1 @T, read r2 @T+1 from other port -> rdata=0001 (RAW correct)
//  6 reset asserted in cycle after a write grant -> rb_ldR=0, rvalid never pulses
//    -> bank unchanged; lock held > LOCK_MAX with RB_LOCK_TIMEOUT_EN -> IDLE, lock_err=1

Source files
------------

// File: rtl/reg_bank_sched.sv
// reg_bank_sched: round-robin two-port scheduler for the 8x16 register bank with RMW lock (lock timeout under RB_LOCK_TIMEOUT_EN).
// Latency: grant in the request cycle; bank write strobe one cycle later; rdata/rvalid two cycles after a read grant.
// Backpressure: a requester holds req and its operands stable until gnt; the loser of a contested cycle wins the next one.
module reg_bank_sched #(
    parameter int DW       = 16,
    parameter int AW       = 3,
    parameter int LOCK_MAX = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          lock_err,
    output logic [AW-1:0] rb_inId,
    output logic          rb_ldR,
    output logic [DW-1:0] rb_rIn,
    output logic [AW-1:0] rb_outId,
    input  logic [DW-1:0] rb_rOut
);

    if (LOCK_MAX < 1 || LOCK_MAX > 15) begin : g_lock_max_chk
        $error("LOCK_MAX must fit the 4-bit lock counter");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          ldr_q, ldr_d;
    logic [AW-1:0] in_id_q, in_id_d;
    logic [DW-1:0] rin_q, rin_d;
    logic [AW-1:0] out_id_q, out_id_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_port_q, rd_port_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;

    logic          lk0, lk1, forced, arb_open;
    logic          gnt_any, win, win_we, win_lk;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

`ifdef RB_LOCK_TIMEOUT_EN
    localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);
    logic [3:0] cnt_q, cnt_d;
    logic       ign0_q, ign0_d;
    logic       ign1_q, ign1_d;
    logic       lock_err_q, lock_err_d;
`endif

    always_comb begin
`ifdef RB_LOCK_TIMEOUT_EN
        // A force-released owner's lock stays masked until it is seen low once.
        forced = (state_q != IDLE) && (cnt_q == LOCK_LIM);
        lk0    = lock0 && !ign0_q && !(forced && state_q == OWN0);
        lk1    = lock1 && !ign1_q && !(forced && state_q == OWN1);
`else
        forced = 1'b0;
        lk0    = lock0;
        lk1    = lock1;
`endif
        // Owner dropping its lock reopens arbitration in that same cycle.
        arb_open = (state_q == IDLE) || forced
                || (state_q == OWN0 && !lk0)
                || (state_q == OWN1 && !lk1);

        gnt_any = 1'b0;
        win     = 1'b0;
        if (arb_open) begin
            if (req0 && req1) begin
                gnt_any = 1'b1;
                win     = ptr_q;
            end else if (req0) begin
                gnt_any = 1'b1;
                win     = 1'b0;
            end else if (req1) begin
                gnt_any = 1'b1;
                win     = 1'b1;
            end
        end else if (state_q == OWN0) begin
            gnt_any = req0;
            win     = 1'b0;
        end else begin
            gnt_any = req1;
            win     = 1'b1;
        end

        win_we    = win ? we1    : we0;
        win_addr  = win ? addr1  : addr0;
        win_wdata = win ? wdata1 : wdata0;
        win_lk    = win ? lk1    : lk0;

        state_d = arb_open ? IDLE : state_q;
        if (gnt_any && win_lk) begin
            state_d = win ? OWN1 : OWN0;
        end
        ptr_d = gnt_any ? ~win : ptr_q;

        ldr_d     = 1'b0;
        in_id_d   = in_id_q;
        rin_d     = rin_q;
        out_id_d  = out_id_q;
        rd_pend_d = 1'b0;
        rd_port_d = rd_port_q;
        if (gnt_any) begin
            if (win_we) begin
                ldr_d   = 1'b1;
                in_id_d = win_addr;
                rin_d   = win_wdata;
            end else begin
                out_id_d  = win_addr;
                rd_pend_d = 1'b1;
                rd_port_d = win;
            end
        end

        rdata_d   = rdata_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        if (rd_pend_q) begin
            rdata_d   = rb_rOut;
            rvalid0_d = !rd_port_q;
            rvalid1_d = rd_port_q;
        end

`ifdef RB_LOCK_TIMEOUT_EN
        cnt_d      = (state_q != IDLE && state_d == state_q) ? cnt_q + 4'd1 : 4'd0;
        ign0_d     = (ign0_q || (forced && state_q == OWN0)) && lock0;
        ign1_d     = (ign1_q || (forced && state_q == OWN1)) && lock1;
        lock_err_d = lock_err_q || forced;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            ldr_q      <= 1'b0;
            in_id_q    <= '0;
            rin_q      <= '0;
            out_id_q   <= '0;
            rd_pend_q  <= 1'b0;
            rd_port_q  <= 1'b0;
            rdata_q    <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
`ifdef RB_LOCK_TIMEOUT_EN
            cnt_q      <= 4'd0;
            ign0_q     <= 1'b0;
            ign1_q     <= 1'b0;
            lock_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ldr_q      <= ldr_d;
            in_id_q    <= in_id_d;
            rin_q      <= rin_d;
            out_id_q   <= out_id_d;
            rd_pend_q  <= rd_pend_d;
            rd_port_q  <= rd_port_d;
            rdata_q    <= rdata_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
`ifdef RB_LOCK_TIMEOUT_EN
            cnt_q      <= cnt_d;
            ign0_q     <= ign0_d;
            ign1_q     <= ign1_d;
            lock_err_q <= lock_err_d;
`endif
        end
    end

    // Reset squashes strobes already in flight so no bank write or rvalid escapes it.
    assign gnt0     = gnt_any && !win && !reset;
    assign gnt1     = gnt_any &&  win && !reset;
    assign rvalid0  = rvalid0_q && !reset;
    assign rvalid1  = rvalid1_q && !reset;
    assign rdata    = rdata_q;
    assign rb_ldR   = ldr_q && !reset;
    assign rb_inId  = in_id_q;
    assign rb_rIn   = rin_q;
    assign rb_outId = out_id_q;
`ifdef RB_LOCK_TIMEOUT_EN
    assign lock_err = lock_err_q;
`else
    assign lock_err = 1'b0;
`endif

endmodule
